// File: rtl/writeback_stage.sv
// writeback_stage: retires memory-stage results, extracts load data, forwards to decode.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_in,
  input  logic [4:0]  mem_rd_in,
  input  logic        mem_rd_valid_in,
  input  logic [31:0] mem_result_in,
  input  logic        mem_is_load_in,
  input  logic [2:0]  mem_funct3_in,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_fwd_valid,
  output logic [4:0]  mem_fwd_rd,
  output logic [31:0] mem_fwd_data,
  output logic        wb_fwd_valid,
  output logic [4:0]  wb_fwd_rd,
  output logic [31:0] wb_fwd_data,
  output logic        stall_pipeline,
  output logic [63:0] retired_count
);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;
  state_t state, state_nx;
  logic [4:0]  cap_rd, sel_rd;
  logic        cap_rdv, sel_rdv;
  logic [2:0]  cap_f3, sel_f3;
  logic [1:0]  cap_off, sel_off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data;
  logic        waiting, load_miss, complete;
  always_comb begin
    waiting        = state == LOAD_WAIT;
    sel_rd         = waiting ? cap_rd  : mem_rd_in;
    sel_rdv        = waiting ? cap_rdv : mem_rd_valid_in;
    sel_f3         = waiting ? cap_f3  : mem_funct3_in;
    sel_off        = waiting ? cap_off : mem_result_in[1:0];
    byte_v         = dmem_rdata[{sel_off, 3'b000} +: 8];
    half_v         = sel_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data        = sel_f3[1:0] == 2'b00 ? {{24{byte_v[7] & ~sel_f3[2]}}, byte_v} :
                     sel_f3[1:0] == 2'b01 ? {{16{half_v[15] & ~sel_f3[2]}}, half_v} : dmem_rdata;
    load_miss      = !waiting && mem_valid_in && mem_is_load_in && !dmem_rvalid;
    complete       = waiting ? dmem_rvalid : mem_valid_in && (!mem_is_load_in || dmem_rvalid);
    mem_fwd_valid  = complete && sel_rdv && sel_rd != 5'd0;
    mem_fwd_rd     = sel_rd;
    mem_fwd_data   = (waiting || mem_is_load_in) ? ld_data : mem_result_in;
    stall_pipeline = waiting && !dmem_rvalid;
    state_nx       = load_miss ? LOAD_WAIT : (waiting && dmem_rvalid) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cap_rd       <= '0;
      cap_rdv      <= 1'b0;
      cap_f3       <= '0;
      cap_off      <= '0;
      wb_fwd_valid <= 1'b0;
      wb_fwd_rd    <= '0;
      wb_fwd_data  <= '0;
    end else begin
      state        <= state_nx;
      wb_fwd_valid <= mem_fwd_valid;
      if (load_miss) begin
        cap_rd  <= mem_rd_in;
        cap_rdv <= mem_rd_valid_in;
        cap_f3  <= mem_funct3_in;
        cap_off <= mem_result_in[1:0];
      end
      if (mem_fwd_valid) begin
        wb_fwd_rd   <= mem_fwd_rd;
        wb_fwd_data <= mem_fwd_data;
      end
    end
  end
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (complete) cnt <= cnt + 64'd1;
  end
  assign retired_count = cnt;
`else
  assign retired_count = '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with a writeback scoreboard for writeback_stage.
module tb_writeback_stage;
  logic        clk = 1'b0, rst = 1'b0;
  logic        mem_valid_in = 0, mem_rd_valid_in = 0, mem_is_load_in = 0, dmem_rvalid = 0;
  logic [4:0]  mem_rd_in = '0;
  logic [31:0] mem_result_in = '0, dmem_rdata = '0;
  logic [2:0]  mem_funct3_in = '0;
  logic        mem_fwd_valid, wb_fwd_valid, stall_pipeline;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic [63:0] retired_count;
  int compared = 0, mismatched = 0;
  longint unsigned exp_ret = 0;
  logic [36:0] sb[$];
  logic [36:0] e;
  writeback_stage dut (
    .clk(clk), .rst(rst), .mem_valid_in(mem_valid_in), .mem_rd_in(mem_rd_in),
    .mem_rd_valid_in(mem_rd_valid_in), .mem_result_in(mem_result_in),
    .mem_is_load_in(mem_is_load_in), .mem_funct3_in(mem_funct3_in),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .stall_pipeline(stall_pipeline), .retired_count(retired_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] rd, input logic rdv, input logic [31:0] res,
                       input logic ld, input logic [2:0] f3, input logic rv, input logic [31:0] rdata);
    @(negedge clk);
    mem_valid_in = v; mem_rd_in = rd; mem_rd_valid_in = rdv; mem_result_in = res;
    mem_is_load_in = ld; mem_funct3_in = f3; dmem_rvalid = rv; dmem_rdata = rdata;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic fwd(input string name, input logic v, input logic [31:0] d, input logic st);
    chk({name, "_fwd_valid"}, 64'(mem_fwd_valid), 64'(v));
    if (v) chk({name, "_fwd_data"}, 64'(mem_fwd_data), 64'(d));
    chk({name, "_stall"}, 64'(stall_pipeline), 64'(st));
  endtask
  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] d);
    sb.push_back({rd, d});
  endtask
  function automatic logic [63:0] ret_exp(input longint unsigned n);
`ifdef WB_RETIRE_CNT_EN
    return 64'(n);
`else
    return 64'(n) & 64'd0;
`endif
  endfunction
  always @(posedge clk) begin
    #1;
    if (wb_fwd_valid) begin
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL wb_spurious: got rd %0d data %0h expected no writeback", wb_fwd_rd, wb_fwd_data);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", 64'(wb_fwd_rd), 64'(e[36:32]));
        chk("wb_data", 64'(wb_fwd_data), 64'(e[31:0]));
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 64'(stall_pipeline), 64'd0);
    chk("rst_wb_valid", 64'(wb_fwd_valid), 64'd0);
    chk("rst_wb_rd", 64'(wb_fwd_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_fwd_data), 64'd0);
    chk("rst_retired", retired_count, 64'd0);
    @(negedge clk); rst = 1'b1;
    drive(1, 5, 1, 32'h0000_00AB, 0, 3'b000, 0, 0);
    fwd("alu_x5", 1, 32'h0000_00AB, 0);
    chk("alu_x5_rd", 64'(mem_fwd_rd), 64'd5);
    expect_wb(5, 32'h0000_00AB); exp_ret++;
    drive(1, 9, 1, 32'h0000_1003, 1, 3'b000, 1, 32'h80FF_FFFF);
    fwd("lb_hit", 1, 32'hFFFF_FF80, 0);
    expect_wb(9, 32'hFFFF_FF80); exp_ret++;
    drive(1, 12, 1, 32'h0000_2002, 1, 3'b101, 0, 0);
    fwd("lhu_miss", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 1, 32'hDEAD, 0, 3'b000, 0, 0);
      fwd("lhu_wait", 0, 0, 1);
      chk("lhu_wait_rd", 64'(mem_fwd_rd), 64'd12);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 32'hBEEF_1234);
    fwd("lhu_resp", 1, 32'h0000_BEEF, 0);
    expect_wb(12, 32'h0000_BEEF); exp_ret++;
    drive(1, 0, 1, 32'h55, 0, 3'b000, 0, 0);
    fwd("alu_x0", 0, 0, 0); exp_ret++;
    drive(0, 6, 1, 32'h66, 0, 3'b000, 1, 32'h1111_2222);
    fwd("idle_rvalid", 0, 0, 0);
    drive(1, 10, 1, 32'h0000_3000, 1, 3'b010, 1, 32'h1234_5678);
    fwd("lw", 1, 32'h1234_5678, 0);
    expect_wb(10, 32'h1234_5678); exp_ret++;
    drive(1, 11, 1, 32'h0000_3002, 1, 3'b001, 1, 32'h8001_0000);
    fwd("lh", 1, 32'hFFFF_8001, 0);
    expect_wb(11, 32'hFFFF_8001); exp_ret++;
    drive(1, 14, 1, 32'h0000_3001, 1, 3'b100, 1, 32'h0000_9A00);
    fwd("lbu", 1, 32'h0000_009A, 0);
    expect_wb(14, 32'h0000_009A); exp_ret++;
    idle(); idle();
    chk("hold_valid", 64'(wb_fwd_valid), 64'd0);
    chk("hold_rd", 64'(wb_fwd_rd), 64'd14);
    chk("hold_data", 64'(wb_fwd_data), 64'h9A);
    chk("retired_7", retired_count, ret_exp(exp_ret));
    drive(1, 20, 1, 32'h0000_4000, 1, 3'b010, 0, 0);
    idle();
    chk("pre_rst_stall", 64'(stall_pipeline), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_stall", 64'(stall_pipeline), 64'd0);
    chk("async_rst_retired", retired_count, 64'd0);
    chk("async_rst_wb_rd", 64'(wb_fwd_rd), 64'd0);
    exp_ret = 0;
    @(negedge clk); rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    fwd("post_rst_rvalid", 0, 0, 0);
    idle();
    chk("post_rst_wb_valid", 64'(wb_fwd_valid), 64'd0);
    chk("post_rst_retired", retired_count, 64'd0);
    drive(1, 4, 0, 32'h100, 0, 3'b010, 0, 0);
    fwd("store", 0, 0, 0); exp_ret++;
    drive(1, 7, 1, 32'h0000_0777, 0, 3'b000, 0, 0);
    fwd("alu_x7", 1, 32'h0000_0777, 0);
    expect_wb(7, 32'h0000_0777); exp_ret++;
    idle(); idle();
    chk("retired_2", retired_count, ret_exp(exp_ret));
    repeat (3) idle();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have mem_valid_in  input  1  memory-stage instruction present this cycle.
REQ-004 SHALL have mem_rd_in  input  5  destination register.
REQ-005 SHALL have mem_rd_valid_in  input  1  instruction writes rd.
REQ-006 SHALL have mem_result_in  input  32  ALU/address result.
REQ-007 SHALL have mem_is_load_in  input  1  instruction is a load.
REQ-008 SHALL have mem_funct3_in  input  3  load width/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-009 SHALL have dmem_rvalid  input  1  data-memory read response valid.
REQ-010 SHALL have dmem_rdata  input  32  aligned data-memory word.
REQ-011 SHALL have mem_fwd_valid / mem_fwd_rd / mem_fwd_data  output  1/5/32  combinational forward to decode.
REQ-012 SHALL have wb_fwd_valid / wb_fwd_rd / wb_fwd_data  output  1/5/32  registered register-file write port and forward.
REQ-013 SHALL have stall_pipeline  output  1  load response outstanding; freeze upstream.
REQ-014 SHALL have retired_count  output  64  retired-instruction count.

Function
REQ-015 SHALL implement FSM states IDLE and LOAD_WAIT.
REQ-016 IDLE, mem_valid_in=1, non-load: SHALL drive mem_fwd_valid=mem_rd_valid_in&&(mem_rd_in!=0), mem_fwd_data=mem_result_in; SHALL register wb_fwd_* on that edge (1-cycle latency).
REQ-017 IDLE, load with dmem_rvalid=1 same cycle: SHALL forward extracted load data on mem_fwd and register it into wb_fwd_* on that edge.
REQ-018 IDLE, load with dmem_rvalid=0: SHALL capture rd, rd_valid, funct3, mem_result_in[1:0] and move to LOAD_WAIT.
REQ-019 LOAD_WAIT: stall_pipeline=1; mem_fwd_rd=captured rd; mem_fwd_valid=0 until dmem_rvalid (decode stalls on rd match).
REQ-020 LOAD_WAIT, dmem_rvalid=1: SHALL forward extracted data, register wb_fwd_*, return to IDLE; stall_pipeline deasserts that same cycle.
REQ-021 Load extraction: byte lane = addr[1:0]*8, halfword = addr[1]*16; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word; misaligned offsets use the selected lane without trap.
REQ-022 wb_fwd_valid SHALL be 1 for exactly one cycle per retired instruction with rd_valid=1 and rd!=0; else 0; wb_fwd_rd/data hold last value when 0.
REQ-023 mem_valid_in during LOAD_WAIT SHALL be ignored; dmem_rvalid in IDLE without a load SHALL be ignored.
REQ-024 mem_fwd_valid SHALL be 0 whenever mem_valid_in=0 in IDLE.

Reset
REQ-025 rst low SHALL asynchronously force state=IDLE, wb_fwd_valid=0, wb_fwd_rd=0, wb_fwd_data=0, retired_count=0, captured fields=0; stall_pipeline=0.
REQ-026 Reset during LOAD_WAIT SHALL discard the pending load; a later dmem_rvalid SHALL produce no writeback.

Configuration
REQ-027 Macro WB_RETIRE_CNT_EN defined: retired_count SHALL increment by 1 at each edge completing an instruction (non-load accept or load response), wrapping 2^64-1 -> 0.
REQ-028 Macro WB_RETIRE_CNT_EN undefined: retired_count SHALL be constant 0 and the counter SHALL not be synthesized.

Verification
REQ-029 ALU op rd=x5, result 0x0000_00AB -> same cycle mem_fwd_valid=1 rd=5; next cycle wb_fwd_valid=1 rd=5 data=0x0000_00AB.
REQ-030 LB addr[1:0]=3, dmem_rdata=0x80FF_FFFF, rvalid same cycle -> wb_fwd_data=0xFFFF_FF80, stall_pipeline never 1.
REQ-031 LHU addr[1:0]=2, rvalid 3 cycles late, rdata=0xBEEF_1234 -> stall_pipeline=1 for 3 cycles, mem_fwd_valid=0 with mem_fwd_rd=rd, then wb_fwd_data=0x0000_BEEF.
REQ-032 ALU op with rd=x0 -> wb_fwd_valid stays 0; retired_count +1 (with WB_RETIRE_CNT_EN).
REQ-033 rst low in LOAD_WAIT, rvalid after release -> state IDLE, wb_fwd_valid stays 0, retired_count=0.
REQ-034 Store (rd_valid=0) followed by ALU op x7 -> one wb_fwd_valid pulse for x7 only; retired_count=2 (with macro), 0 (without).
